// File: rtl/lcd_bus_driver.sv
// ---------------------------------------------------------------------------
// lcd_bus_driver
//
// Purpose:
//   Write-only driver for an HD44780-style parallel LCD bus.
//   - A one-cycle start request latches RS and the data byte, then runs a
//     timed SETUP -> PULSE -> HOLD enable-strobe sequence.
//   - A single 8-bit down-counter times every state.
//   - done pulses for one clock when the write completes.
//
// Configuration:
//   LCD_DRV_4BIT_EN  When defined, selects 4-bit bus mode.
//                    - Each write runs two full sequences: the high nibble
//                      first, then the low nibble.
//                    - The nibble is driven on lcd_data[7:4].
//                    - lcd_data[3:0] is driven to 0.
//                    When undefined, one sequence drives the full byte.
//
// Parameters:
//   SETUP_CYC  clocks with lcd_e low and bus stable before the pulse (1..255)
//   PULSE_CYC  clocks lcd_e is held high                            (1..255)
//   HOLD_CYC   clocks lcd_e is low after the pulse before completion (1..255)
//
// Ports:
//   clk       in   single clock
//   reset     in   synchronous active-high reset
//   start     in   one-cycle write request (ignored while busy)
//   RS        in   register select for the request (0 cmd, 1 data)
//   data      in   byte to write
//   done      out  one-cycle completion pulse
//   busy      out  high while a write is in progress
//   lcd_e     out  LCD enable strobe
//   lcd_rs    out  LCD register select
//   lcd_rw    out  LCD read/write, always 0
//   lcd_data  out  LCD data bus DB7..DB0
// ---------------------------------------------------------------------------
module lcd_bus_driver #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned PULSE_CYC = 12,
   parameter int unsigned HOLD_CYC  = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       RS,
   input  logic [7:0] data,
   output logic       done,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Counter reload values: a state lasts N clocks when loaded with N-1.
   localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
   localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
   localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   logic       done_q, done_d;
   logic       busy_q, busy_d;
   logic       lcd_e_q, lcd_e_d;
   logic       lcd_rs_q, lcd_rs_d;
   logic [7:0] lcd_data_q, lcd_data_d;

   logic       cnt_zero;
   logic       last_nib;   // high when the current sequence ends the write

   assign cnt_zero = (cnt_q == 8'd0);

`ifdef LCD_DRV_4BIT_EN
   // nib_q: 0 while the high nibble is on the bus, 1 for the low nibble.
   // lo_q keeps the low nibble, because data is only sampled at acceptance.
   logic       nib_q, nib_d;
   logic [3:0] lo_q, lo_d;

   assign last_nib = nib_q;
`else
   assign last_nib = 1'b1;
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and counter logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt_zero) begin
               state_d = PULSE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         PULSE: begin
            if (cnt_zero) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               // In 4-bit mode the first HOLD chains straight into the
               // second nibble's SETUP, so busy never drops between nibbles.
               if (last_nib) begin
                  state_d = IDLE;
                  cnt_d   = 8'd0;
               end else begin
                  state_d = SETUP;
                  cnt_d   = SETUP_LD;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output next-state logic
   //   All bus outputs are registered, so they change on the same edge
   //   as the state transition that causes them.
   // ------------------------------------------------------------------
   always_comb begin
      done_d     = 1'b0;
      busy_d     = busy_q;
      lcd_rs_d   = lcd_rs_q;
      lcd_data_d = lcd_data_q;
      lcd_e_d    = (state_d == PULSE);
`ifdef LCD_DRV_4BIT_EN
      nib_d      = nib_q;
      lo_d       = lo_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               busy_d   = 1'b1;
               lcd_rs_d = RS;
`ifdef LCD_DRV_4BIT_EN
               lcd_data_d = {data[7:4], 4'h0};
               lo_d       = data[3:0];
               nib_d      = 1'b0;
`else
               lcd_data_d = data;
`endif
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               if (last_nib) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end
`ifdef LCD_DRV_4BIT_EN
               else begin
                  nib_d      = 1'b1;
                  lcd_data_d = {lo_q, 4'h0};
               end
`endif
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         lcd_e_q    <= 1'b0;
         lcd_rs_q   <= 1'b0;
         lcd_data_q <= 8'h00;
`ifdef LCD_DRV_4BIT_EN
         nib_q      <= 1'b0;
         lo_q       <= 4'h0;
`endif
      end else begin
         done_q     <= done_d;
         busy_q     <= busy_d;
         lcd_e_q    <= lcd_e_d;
         lcd_rs_q   <= lcd_rs_d;
         lcd_data_q <= lcd_data_d;
`ifdef LCD_DRV_4BIT_EN
         nib_q      <= nib_d;
         lo_q       <= lo_d;
`endif
      end
   end

   assign done     = done_q;
   assign busy     = busy_q;
   assign lcd_e    = lcd_e_q;
   assign lcd_rs   = lcd_rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_driver
//
// Drives lcd_bus_driver at default timing.
//   - A behavioural model predicts every output from the time elapsed since
//     the last accepted start; outputs are compared on every falling edge.
//   - Directed writes pin latency, strobe position, data stability, ignored
//     starts, reset abort, and back-to-back operation with literal values.
//   - A randomized phase follows the directed writes.
// ---------------------------------------------------------------------------
module tb_lcd_bus_driver;

   localparam int S = 2;
   localparam int P = 12;
   localparam int H = 12;
   localparam int L = S + P + H;
`ifdef LCD_DRV_4BIT_EN
   localparam int NIB = 2;
`else
   localparam int NIB = 1;
`endif
   localparam int LT = NIB * L;   // accept edge to done edge

   logic       clk = 1'b0;
   logic       reset, start, RS;
   logic [7:0] data;
   logic       done, busy, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;

   lcd_bus_driver #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
      .clk(clk), .reset(reset), .start(start), .RS(RS), .data(data),
      .done(done), .busy(busy), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_data(lcd_data)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int a     = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The model tracks t = edges since the accepting edge.
   //   - The sequence for nibble k spans t in [k*L, (k+1)*L).
   //   - The strobe is high for offsets S..S+P-1 within a sequence.
   //   - done fires at t = LT.
   bit         m_act  = 1'b0;
   int         m_t    = 0;
   logic [7:0] m_byte = 8'h00;
   logic       m_rs = 1'b0, m_done = 1'b0, m_busy = 1'b0, m_e = 1'b0;
   logic [7:0] m_data = 8'h00;

   task automatic model_step();
      int k;
      int o;
      if (reset) begin
         m_act  = 1'b0;
         m_rs   = 1'b0;
         m_data = 8'h00;
         m_done = 1'b0;
         m_busy = 1'b0;
         m_e    = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_act) begin
            m_t++;
         end else if (start) begin
            m_act  = 1'b1;
            m_t    = 0;
            m_rs   = RS;
            m_byte = data;
         end
         if (m_act) begin
            k = m_t / L;
            if (k > NIB - 1) k = NIB - 1;
            o = m_t - k * L;
            m_busy = (m_t < LT);
            m_done = (m_t == LT);
            m_e    = m_busy && (o >= S) && (o < S + P);
            if (NIB == 1) m_data = m_byte;
            else if (k == 0) m_data = {m_byte[7:4], 4'h0};
            else m_data = {m_byte[3:0], 4'h0};
            if (m_done) m_act = 1'b0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("done", done, m_done);
         check("busy", busy, m_busy);
         check("lcd_e", lcd_e, m_e);
         check("lcd_rs", lcd_rs, m_rs);
         check("lcd_data", lcd_data, m_data);
         check("lcd_rw", lcd_rw, 1'b0);
      end
   end

   // ---------------- directed helpers ----------------
   // Present a request, then return at the negedge after its accepting edge.
   task automatic issue(input logic rs, input logic [7:0] d);
      @(posedge clk);
      #2;
      start = 1'b1;
      RS    = rs;
      data  = d;
      @(posedge clk);
      @(negedge clk);
      a     = cyc;
      start = 1'b0;
   endtask

   // Scan negedges for the first strobe and for done (bounded).
   task automatic run_to_done(output int rise, output int dat);
      rise = -1;
      dat  = -1;
      for (int i = 0; i < 4 * LT; i++) begin
         if (lcd_e && rise < 0) rise = cyc - a;
         if (done) begin
            dat = cyc - a;
            break;
         end
         @(negedge clk);
      end
   endtask

   int rise, dat, nd;

   initial begin
      reset = 1'b1;
      start = 1'b1;   // must be ignored under reset
      RS    = 1'b1;
      data  = 8'hEE;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst busy", busy, 1'b0);
      check("rst data", lcd_data, 8'h00);
      check("rst e", lcd_e, 1'b0);
      check("rst done", done, 1'b0);
      #2 reset = 1'b0;
      start = 1'b0;

      // Basic command write.
      issue(1'b0, 8'h38);
`ifdef LCD_DRV_4BIT_EN
      check("w1 latch data", lcd_data, 8'h30);
`else
      check("w1 latch data", lcd_data, 8'h38);
`endif
      check("w1 latch rs", lcd_rs, 1'b0);
      check("w1 busy", busy, 1'b1);
      run_to_done(rise, dat);
      check("w1 e rise", rise, 32'(S));
      check("w1 done at", dat, 32'(LT));
      @(negedge clk);
      check("w1 done width", done, 1'b0);
      check("w1 busy after", busy, 1'b0);

      // Data changes after acceptance must not reach the bus.
      issue(1'b1, 8'h41);
      repeat (5) @(negedge clk);
      data = 8'hFF;
      run_to_done(rise, dat);
`ifdef LCD_DRV_4BIT_EN
      check("w2 data at done", lcd_data, 8'h10);
`else
      check("w2 data at done", lcd_data, 8'h41);
`endif
      check("w2 rs at done", lcd_rs, 1'b1);
      check("w2 done at", dat, 32'(LT));

      // Second start mid-write is ignored.
      issue(1'b0, 8'h12);
      repeat (9) @(negedge clk);
      #2 start = 1'b1;
      data = 8'h99;
      @(posedge clk);
      #2 start = 1'b0;
      nd = 0;
      repeat (LT + 40) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("w3 single done", nd, 1);

      // Reset in PULSE aborts the write.
      issue(1'b0, 8'h55);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("w4 e after rst", lcd_e, 1'b0);
      check("w4 busy after rst", busy, 1'b0);
      nd = 0;
      repeat (LT + 20) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("w4 no done", nd, 0);
      issue(1'b1, 8'h77);
      run_to_done(rise, dat);
      check("w4 restart done at", dat, 32'(LT));

      // Start held high: each write is accepted right after the previous done.
      @(posedge clk);
      #2 start = 1'b1;
      RS   = 1'b1;
      data = 8'hC3;
      nd   = 0;
      repeat (3 * (LT + 1)) begin
         @(negedge clk);
         if (done) nd++;
      end
      start = 1'b0;
      repeat (LT + 10) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("b2b done count", nd, 3);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #2;
         start = ($urandom_range(0, 7) == 0);
         RS    = 1'($urandom);
         data  = 8'($urandom);
         reset = ($urandom_range(0, 299) == 0);
      end
      #2;
      reset = 1'b0;
      start = 1'b0;
      repeat (LT + 5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
